// File: rtl/prbs4_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : prbs4_checker
// Description : Self-synchronising receive checker for the x^4+x^3+1 LFSR word
//               stream. Hunts, tracks, locks, then flywheels and counts errors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module prbs4_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       data_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int c_RUN_W = $clog2(LOCK_CNT + 1);
    localparam int c_BAD_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [1:0]       c_ST_HUNT   = 2'd0;
    localparam logic [1:0]       c_ST_TRACK  = 2'd1;
    localparam logic [1:0]       c_ST_LOCKED = 2'd2;
    localparam logic [ERR_W-1:0] c_CNT_MAX   = {ERR_W{1'b1}};
    localparam logic [c_RUN_W-1:0] c_RUN_LOCK = c_RUN_W'(LOCK_CNT);
    localparam logic [c_BAD_W-1:0] c_BAD_DROP = c_BAD_W'(UNLOCK_CNT);

    function automatic logic [3:0] f_next(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    logic [1:0]         r_state_q,     w_state_d;
    logic [3:0]         r_ref_q,       w_ref_d;
    logic [3:0]         r_exp_q,       w_exp_d;
    logic [c_RUN_W-1:0] r_run_q,       w_run_d;
    logic [c_BAD_W-1:0] r_bad_q,       w_bad_d;
    logic               r_locked_q,    w_locked_d;
    logic               r_err_q,       w_err_d;
    logic [ERR_W-1:0]   r_err_count_q, w_err_count_d;

    logic [c_RUN_W-1:0] w_run_inc;
    logic [c_BAD_W-1:0] w_bad_inc;

    assign w_run_inc = r_run_q + c_RUN_W'(1);
    assign w_bad_inc = r_bad_q + c_BAD_W'(1);

    always_comb begin
        w_state_d     = r_state_q;
        w_ref_d       = r_ref_q;
        w_exp_d       = r_exp_q;
        w_run_d       = r_run_q;
        w_bad_d       = r_bad_q;
        w_err_d       = 1'b0;
        w_err_count_d = r_err_count_q;

        if (en) begin
            case (r_state_q)
                c_ST_HUNT: begin
                    if (data_in != 4'd0) begin
                        w_ref_d   = data_in;
                        w_run_d   = '0;
                        w_state_d = c_ST_TRACK;
                    end
                end
                c_ST_TRACK: begin
                    w_ref_d = data_in;
                    if (data_in == f_next(r_ref_q)) begin
                        w_run_d = w_run_inc;
                        if (w_run_inc == c_RUN_LOCK) begin
                            w_state_d = c_ST_LOCKED;
                            w_exp_d   = f_next(data_in);
                            w_bad_d   = '0;
                        end
                    end else begin
                        w_run_d = '0;
                        if (data_in == 4'd0) begin
                            w_state_d = c_ST_HUNT;
                        end
                    end
                end
                c_ST_LOCKED: begin
                    // Flywheel: expected word never reseeded from received data
                    w_exp_d = f_next(r_exp_q);
                    if (data_in == r_exp_q) begin
                        w_bad_d = '0;
                    end else begin
                        w_err_d = 1'b1;
                        if (r_err_count_q != c_CNT_MAX) begin
                            w_err_count_d = r_err_count_q + ERR_W'(1);
                        end
                        w_bad_d = w_bad_inc;
                        if (w_bad_inc == c_BAD_DROP) begin
                            w_state_d = c_ST_HUNT;
                            w_bad_d   = '0;
                            w_run_d   = '0;
                        end
                    end
                end
                default: begin
                    w_state_d = c_ST_HUNT;
                end
            endcase
        end

        if (clr_cnt) begin
            w_err_count_d = '0;
        end

        w_locked_d = (w_state_d == c_ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_HUNT;
            r_ref_q       <= 4'd0;
            r_exp_q       <= 4'd0;
            r_run_q       <= '0;
            r_bad_q       <= '0;
            r_locked_q    <= 1'b0;
            r_err_q       <= 1'b0;
            r_err_count_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ref_q       <= w_ref_d;
            r_exp_q       <= w_exp_d;
            r_run_q       <= w_run_d;
            r_bad_q       <= w_bad_d;
            r_locked_q    <= w_locked_d;
            r_err_q       <= w_err_d;
            r_err_count_q <= w_err_count_d;
        end
    end

    assign locked    = r_locked_q;
    assign err       = r_err_q;
    assign err_count = r_err_count_q;

endmodule
`default_nettype wire
